// File: rtl/regfile_param.sv
// ---------------------------------------------------------------------------
// regfile_param -- parameterised NREG x XLEN register file for the
// decode/writeback stage of the multi-cycle datapath.
//
// Two registered read ports, one write port, and a hardware clear sequencer.
// After reset, or after a clear_req pulse in RUN, the file is swept to zero
// one entry per cycle. While the sweep runs, ready is low and all accesses
// are ignored.
//
// Optional feature:
//   REGFILE_BYPASS_EN - when defined, a write accepted in a cycle is
//                       forwarded to a read port that reads the same index in
//                       that cycle. A hardwired zero register still reads 0.
//
// Parameters:
//   XLEN     data width
//   NREG     number of registers (power of two, 2..256)
//   ZERO_REG 1: register 0 reads as zero and ignores writes
//   AW       index width, derived from NREG
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   en                  register-stage strobe from the control FSM
//   clear_req           one-cycle request for a full zero-fill
//   rs1, rs2            read indices
//   rd, writedata       write index and data
//   regwrite            write request, qualified by en
//   readdata1/2         registered read data, one cycle after the index
//   ready               1 once the file holds defined values
// ---------------------------------------------------------------------------

// One read port: selects the storage word and applies forwarding and the
// zero-register override. The override comes last so it always wins.
module regfile_param_rdport #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter bit BYPASS   = 1'b0
) (
  input  logic [NREG-1:0][XLEN-1:0] mem,
  input  logic [AW-1:0]             idx,
  input  logic                      wr_acc,
  input  logic [AW-1:0]             wr_idx,
  input  logic [XLEN-1:0]           wr_data,
  output logic [XLEN-1:0]           rdata
);

  always_comb begin
    rdata = mem[idx];
    if (BYPASS && wr_acc && (wr_idx == idx)) rdata = wr_data;
    if ((ZERO_REG != 0) && (idx == '0))      rdata = '0;
  end

endmodule

module regfile_param #(
  parameter  int XLEN     = 32,
  parameter  int NREG     = 32,
  parameter  int ZERO_REG = 1,
  localparam int AW       = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            clear_req,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] writedata,
  input  logic            regwrite,
  output logic [XLEN-1:0] readdata1,
  output logic [XLEN-1:0] readdata2,
  output logic            ready
);

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam int            NPORT    = 2;
  localparam logic [AW-1:0] CNT_LAST = AW'(NREG - 1);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t                       state_q, state_d;
  logic [AW-1:0]                cnt_q, cnt_d;
  logic                         ready_q, ready_d;
  logic [NREG-1:0][XLEN-1:0]    mem_q, mem_d;
  logic [NPORT-1:0][XLEN-1:0]   rdata_q, rdata_d;
  logic [NPORT-1:0][XLEN-1:0]   rd_val;
  logic [NPORT-1:0][AW-1:0]     rs_idx;
  logic                         wr_acc;

  assign rs_idx = {rs2, rs1};

  // A write lands only in RUN with the stage enabled; a clear request in the
  // same cycle drops it (and therefore also suppresses any forwarding).
  assign wr_acc = (state_q == ST_RUN) && en && regwrite && !clear_req &&
                  !((ZERO_REG != 0) && (rd == '0));

  for (genvar p = 0; p < NPORT; p++) begin : g_rd
    regfile_param_rdport #(
      .XLEN     (XLEN),
      .NREG     (NREG),
      .AW       (AW),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rd (
      .mem     (mem_q),
      .idx     (rs_idx[p]),
      .wr_acc  (wr_acc),
      .wr_idx  (rd),
      .wr_data (writedata),
      .rdata   (rd_val[p])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_CLEAR: begin
        // Sweep: one entry per cycle, counter wraps to 0 on the last one.
        mem_d[cnt_q] = '0;
        cnt_d        = cnt_q + AW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (en) rdata_d = rd_val;
        if (wr_acc) mem_d[rd] = writedata;
        if (clear_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
    ready_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage has no reset of its own; the sweep that follows reset clears it.
  always_ff @(posedge clk) begin
    if (!reset) mem_q <= mem_d;
  end

  assign readdata1 = rdata_q[0];
  assign readdata2 = rdata_q[1];
  assign ready     = ready_q;

endmodule

// File: tb/tb_regfile_param.sv
module tb_regfile_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: defaults (XLEN=32, NREG=32, ZERO_REG=1)
  logic        reset, en, clear_req, regwrite;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] writedata, readdata1, readdata2;
  logic        ready;

  // DUT B: XLEN=64, NREG=16, ZERO_REG=0
  logic        reset_b, en_b, clear_req_b, regwrite_b;
  logic [3:0]  rs1_b, rs2_b, rd_b;
  logic [63:0] writedata_b, readdata1_b, readdata2_b;
  logic        ready_b;

  regfile_param dut (
    .clk(clk), .reset(reset), .en(en), .clear_req(clear_req),
    .rs1(rs1), .rs2(rs2), .rd(rd), .writedata(writedata),
    .regwrite(regwrite), .readdata1(readdata1), .readdata2(readdata2),
    .ready(ready)
  );

  regfile_param #(.XLEN(64), .NREG(16), .ZERO_REG(0)) dut_b (
    .clk(clk), .reset(reset_b), .en(en_b), .clear_req(clear_req_b),
    .rs1(rs1_b), .rs2(rs2_b), .rd(rd_b), .writedata(writedata_b),
    .regwrite(regwrite_b), .readdata1(readdata1_b), .readdata2(readdata2_b),
    .ready(ready_b)
  );

  typedef struct {
    int          due;
    int          which;
    bit          is_rdy;
    logic [63:0] e1;
    logic [63:0] e2;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic exp_rd(input int which, input int due, input string nm,
                        input logic [63:0] e1, input logic [63:0] e2);
    exp_t e;
    e.due = due; e.which = which; e.is_rdy = 1'b0; e.e1 = e1; e.e2 = e2; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic exp_rdy(input int which, input int due, input string nm, input bit v);
    exp_t e;
    e.due = due; e.which = which; e.is_rdy = 1'b1; e.e1 = {63'b0, v}; e.e2 = '0; e.nm = nm;
    q.push_back(e);
  endtask

  // Monitor: at each falling edge, checks every expectation due this cycle.
  always @(negedge clk) begin
    logic [63:0] a1, a2;
    logic        ar;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].due == cyc) begin
        if (q[i].is_rdy) begin
          ar = (q[i].which == 0) ? ready : ready_b;
          total++;
          if (ar !== q[i].e1[0]) begin
            bad++;
            $display("FAIL %s cyc=%0d ready got %b want %b", q[i].nm, cyc, ar, q[i].e1[0]);
          end
        end else begin
          a1 = (q[i].which == 0) ? {32'b0, readdata1} : readdata1_b;
          a2 = (q[i].which == 0) ? {32'b0, readdata2} : readdata2_b;
          total++;
          if (a1 !== q[i].e1) begin
            bad++;
            $display("FAIL %s cyc=%0d readdata1 got %h want %h", q[i].nm, cyc, a1, q[i].e1);
          end
          total++;
          if (a2 !== q[i].e2) begin
            bad++;
            $display("FAIL %s cyc=%0d readdata2 got %h want %h", q[i].nm, cyc, a2, q[i].e2);
          end
        end
        q.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a DUT A access sampled at the next edge.
  task automatic acc(input bit e, input bit w, input logic [4:0] d, input logic [31:0] wd,
                     input logic [4:0] r1, input logic [4:0] r2, input bit clr);
    en = e; regwrite = w; rd = d; writedata = wd; rs1 = r1; rs2 = r2; clear_req = clr;
  endtask

  task automatic idle();
    acc(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
  endtask

  initial begin
    int c, d, r;
    reset = 1'b1; idle();
    reset_b = 1'b1; en_b = 0; clear_req_b = 0; regwrite_b = 0;
    rs1_b = 0; rs2_b = 0; rd_b = 0; writedata_b = '0;
    step();                         // reset applied at edge 1
    reset = 1'b0; reset_b = 1'b0;

    // 1. reset state and sweep lengths (32 for A, 16 for B)
    exp_rd(0, cyc, "rst_rdata", 64'd0, 64'd0);
    exp_rd(1, cyc, "rst_rdata_b", 64'd0, 64'd0);
    for (int k = 0; k < 32; k++) exp_rdy(0, cyc + k, "init_clear", 1'b0);
    exp_rdy(0, cyc + 32, "init_ready", 1'b1);
    for (int k = 0; k < 16; k++) exp_rdy(1, cyc + k, "init_clear_b", 1'b0);
    exp_rdy(1, cyc + 16, "init_ready_b", 1'b1);
    for (int k = 0; k < 32; k++) step();

    // every index reads 0
    for (int i = 0; i < 32; i++) begin
      acc(1'b1, 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 1'b0);
      exp_rd(0, cyc + 1, "init_zero", 64'd0, 64'd0);
      step();
    end

    // 2. write r5, read back, en=0 holds
    acc(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0); step();
    acc(1'b1, 1'b0, 5'd0, 32'd0, 5'd5, 5'd1, 1'b0);
    exp_rd(0, cyc + 1, "wr_rd5", 64'hDEADBEEF, 64'd0); step();
    acc(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    exp_rd(0, cyc + 1, "en0_hold", 64'hDEADBEEF, 64'd0); step();

    // 3. register 0 hardwired to zero
    acc(1'b1, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 1'b0); step();
    acc(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    exp_rd(0, cyc + 1, "zero_reg", 64'd0, 64'd0); step();

    // 4. same-cycle write/read of r7
    acc(1'b1, 1'b1, 5'd7, 32'h11, 5'd0, 5'd0, 1'b0); step();
    acc(1'b1, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, 1'b0);
`ifdef REGFILE_BYPASS_EN
    exp_rd(0, cyc + 1, "same_cyc_rw", 64'hA5A5A5A5, 64'hA5A5A5A5);
`else
    exp_rd(0, cyc + 1, "same_cyc_rw", 64'h11, 64'h11);
`endif
    step();
    acc(1'b1, 1'b0, 5'd0, 32'd0, 5'd7, 5'd5, 1'b0);
    exp_rd(0, cyc + 1, "after_rw", 64'hA5A5A5A5, 64'hDEADBEEF); step();

    // 5. fill 1..31 with index, then clear_req colliding with a write
    for (int i = 1; i < 32; i++) begin
      acc(1'b1, 1'b1, 5'(i), 32'(i), 5'd0, 5'd0, 1'b0); step();
    end
    acc(1'b1, 1'b0, 5'd0, 32'd0, 5'd3, 5'd31, 1'b0);
    exp_rd(0, cyc + 1, "fill_rd", 64'd3, 64'd31); step();
    c = cyc;
    acc(1'b1, 1'b1, 5'd3, 32'hFF, 5'd3, 5'd30, 1'b1);
    exp_rd(0, c + 1, "clr_read", 64'd3, 64'd30);
    for (int k = 1; k <= 32; k++) exp_rdy(0, c + k, "clr_busy", 1'b0);
    exp_rdy(0, c + 33, "clr_ready", 1'b1);
    step();
    // accesses during the sweep are ignored; outputs hold
    acc(1'b1, 1'b1, 5'd5, 32'h55, 5'd5, 5'd6, 1'b0);
    exp_rd(0, c + 2, "clr_hold", 64'd3, 64'd30);
    exp_rd(0, c + 20, "clr_hold2", 64'd3, 64'd30);
    for (int k = 0; k < 5; k++) step();
    clear_req = 1'b1; step();       // ignored mid-sweep
    clear_req = 1'b0;
    while (cyc < c + 30) step();
    idle();
    while (cyc < c + 33) step();
    for (int i = 0; i < 32; i++) begin
      acc(1'b1, 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 1'b0);
      exp_rd(0, cyc + 1, "post_clr_zero", 64'd0, 64'd0);
      step();
    end

    // 6. reset at sweep count 10 restarts a full sweep
    acc(1'b1, 1'b1, 5'd4, 32'h44, 5'd0, 5'd0, 1'b0); step();
    acc(1'b1, 1'b0, 5'd0, 32'd0, 5'd4, 5'd4, 1'b0);
    exp_rd(0, cyc + 1, "pre_rst_rd", 64'h44, 64'h44); step();
    d = cyc;
    acc(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1); step();
    clear_req = 1'b0;
    while (cyc < d + 11) step();
    reset = 1'b1;
    r = cyc + 1;
    exp_rd(0, r, "mid_rst_rdata", 64'd0, 64'd0);
    for (int k = 0; k < 32; k++) exp_rdy(0, r + k, "mid_rst_clear", 1'b0);
    exp_rdy(0, r + 32, "mid_rst_ready", 1'b1);
    step();
    reset = 1'b0;
    while (cyc < r + 32) step();
    acc(1'b1, 1'b1, 5'd9, 32'hCAFEF00D, 5'd0, 5'd0, 1'b0); step();
    acc(1'b1, 1'b0, 5'd0, 32'd0, 5'd9, 5'd4, 1'b0);
    exp_rd(0, cyc + 1, "post_rst_rt", 64'hCAFEF00D, 64'd0); step();
    idle();

    // DUT B: ZERO_REG=0 register 0 is storage; 64-bit round-trip
    en_b = 1; regwrite_b = 1; rd_b = 4'd0; writedata_b = 64'h12345678; step();
    rd_b = 4'd9; writedata_b = 64'hFEDCBA9876543210; rs1_b = 4'd0; rs2_b = 4'd0;
    exp_rd(1, cyc + 1, "b_reg0", 64'h12345678, 64'h12345678); step();
    regwrite_b = 0; rs1_b = 4'd9; rs2_b = 4'd0;
    exp_rd(1, cyc + 1, "b_rt64", 64'hFEDCBA9876543210, 64'h12345678); step();
    en_b = 0;

    step(); step();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL leftover_expectations got %0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor of the single-cycle CPU register file: NREG x XLEN storage, two registered read ports, one write port.
- Sits in the decode/writeback stage of the multi-cycle datapath; `en` replaces the hard-coded state gating.
- Adds a hardware clear sequencer and a `ready` handshake so the controller knows when the file holds defined values.
- Optional write-to-read bypass.

Parameters:
- XLEN, 32, data width in bits.
- NREG, 32, number of registers; power of two, 2..256.
- AW, $clog2(NREG), index width; localparam, not overridable.
- ZERO_REG, 1, if 1 register 0 is hardwired to zero; if 0 register 0 is ordinary storage.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- en  in  1  operation enable, the "register stage active" strobe from the control FSM.
- clear_req  in  1  single-cycle pulse requesting a full zero-fill of the file.
- rs1  in  AW  read index, port 1.
- rs2  in  AW  read index, port 2.
- rd  in  AW  write index.
- writedata  in  XLEN  write data.
- regwrite  in  1  write request, qualified by en.
- readdata1  out  XLEN  registered read data, port 1.
- readdata2  out  XLEN  registered read data, port 2.
- ready  out  1  1 = file initialised, accepting reads and writes.

Behaviour:
- Reset (sync, active-high, clk edge):
  - FSM enters CLEAR; sweep counter = 0.
  - readdata1 = readdata2 = 0; ready = 0.
  - Storage is not reset directly; the sweep clears it.
- FSM states:
  - CLEAR:
    - Each cycle writes 0 to storage[counter], then counter++.
    - When counter == NREG-1 is written, go to RUN next edge; counter wraps to 0.
    - ready = 0 throughout; CLEAR lasts exactly NREG cycles.
    - en, regwrite, rs1 and rs2 are ignored; readdata1/2 hold their previous value.
  - RUN: ready = 1; normal operation.
    - clear_req = 1 moves the FSM to CLEAR next edge with counter = 0.
- RUN, en = 1:
  - Write: if regwrite = 1 and not (ZERO_REG = 1 and rd == 0), storage[rd] <= writedata at this edge.
  - Read: readdata1 <= storage[rs1], readdata2 <= storage[rs2] at the same edge. Latency is 1 cycle from index presentation.
  - Without bypass, a same-cycle read of rd returns the old value.
  - ZERO_REG = 1: a read of index 0 always returns 0.
- RUN, en = 0: no write; readdata1/2 hold.
- Simultaneous events:
  - clear_req and a write in the same RUN cycle: clear_req wins; the write is dropped. The read still completes this cycle.
  - clear_req during CLEAR is ignored; the sweep is not restarted.
  - reset during CLEAR restarts the sweep at 0.
  - rs1 == rs2: both ports return the identical value.
- Index widths are exactly AW; no out-of-range indices exist because NREG is a power of two.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: in RUN with en = 1, if a write is accepted and rd == rs1, then readdata1 <= writedata in place of the old storage value. Same rule for rs2/readdata2.
  - The ZERO_REG rule has priority: a read of index 0 returns 0 when ZERO_REG = 1.
  - A write dropped by clear_req produces no bypass.
- Undefined: no forwarding; same-cycle read of rd returns the pre-write value.

Test Plan:
1. Reset 1 cycle, then idle.
   - ready = 0 for exactly 32 cycles, then 1.
   - Read of every index returns 0.
   - readdata1/2 = 0 right after reset.
2. RUN, en = 1, regwrite = 1, rd = 5, writedata = 0xDEADBEEF; next cycle rs1 = 5.
   - readdata1 = 0xDEADBEEF one cycle after rs1 is presented.
   - en = 0 the following cycle: readdata1 holds.
3. Write rd = 0, writedata = 0x12345678, ZERO_REG = 1, then read rs1 = rs2 = 0.
   - Both ports = 0.
   - With ZERO_REG = 0: both ports = 0x12345678.
4. Write rd = 7 with rs1 = 7 in the same cycle, regwrite = 1, writedata = 0xA5A5A5A5; storage[7] previously 0x11.
   - With REGFILE_BYPASS_EN: readdata1 = 0xA5A5A5A5.
   - Without it: readdata1 = 0x11; next read returns 0xA5A5A5A5.
5. Fill regs 1..31 with index values, then pulse clear_req together with a write rd = 3, writedata = 0xFF.
   - ready = 0 for 32 cycles.
   - Afterwards all registers read 0, including reg 3; the write was dropped.
6. Assert reset at sweep count 10, release.
   - A full 32-cycle CLEAR follows.
   - Params XLEN = 64, NREG = 16: ready rises after 16 cycles; a 64-bit write/read round-trip of 0xFEDCBA9876543210 matches.
